power_switch_seq: RTL



---
 rtl/power_switch_pkg.sv | 33 +++
 rtl/power_switch_debounce.sv | 51 +++++
 rtl/power_switch_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/power_switch_pkg.sv
// Shared types and constants for the user-area power switch sequencer.
package power_switch_pkg;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_ON        = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  // Word index within the 16-byte register window (adr[3:2]).
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_STEP     = 2'd1;
  localparam logic [1:0] REG_DEBOUNCE = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam int CTRL_SW_EN  = 0;
  localparam int CTRL_SRC    = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_PG   = 4;
  localparam int STAT_PEND = 5;
  localparam int STAT_GATE = 8;

  localparam logic [15:0] STEP_DEFAULT = 16'd100;
  localparam logic [15:0] DEB_DEFAULT  = 16'd1000;

  // Timer reload: a STEP of 0 behaves like 1.
  function automatic logic [15:0] step_reload(input logic [15:0] step);
    return (step == 16'd0) ? 16'd0 : step - 16'd1;
  endfunction

endpackage

// File: rtl/power_switch_debounce.sv
// Pad synchronizer followed by a stable-count debouncer.
module power_switch_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pin,
  input  logic [CW-1:0] threshold,
  output logic          level
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_next;
  logic [CW:0]            count_inc;
  logic                   level_next;

  assign synced    = sync[SYNC_STAGES-1];
  assign count_inc = {1'b0, count} + {{CW{1'b0}}, 1'b1};

  // Flip once the disagreement has persisted for threshold cycles (0 acts like 1).
  always_comb begin
    count_next = count;
    level_next = level;
    if (synced != level) begin
      if (count_inc >= {1'b0, threshold}) begin
        level_next = ~level;
        count_next = {CW{1'b0}};
      end else begin
        count_next = count_inc[CW-1:0];
      end
    end else begin
      count_next = {CW{1'b0}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= {SYNC_STAGES{1'b0}};
      count <= {CW{1'b0}};
      level <= 1'b0;
    end else begin
      sync  <= (sync << 1) | SYNC_STAGES'(pin);
      count <= count_next;
      level <= level_next;
    end
  end

endmodule

// File: rtl/power_switch_seq.sv
// Power switch gate sequencer: Wishbone register file, request selection,
// and a segment-at-a-time ramp FSM driving the switch gates.
module power_switch_seq
  import power_switch_pkg::*;
#(
  parameter int          N_SEG       = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] STEP_RST    = STEP_DEFAULT,
  parameter logic [15:0] DEB_RST     = DEB_DEFAULT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic             pin_req_i,
  output logic [N_SEG-1:0] gate_o,
  output logic             pg_o,
  output logic             irq_o
);

  state_t           state, state_next;
  logic [N_SEG-1:0] gate, gate_next, gate_up, gate_dn;
  logic [15:0]      timer, timer_next, reload;
  logic             pg, pg_next;
  logic [2:0]       ctrl, ctrl_next;
  logic [15:0]      step, step_next;
  logic [15:0]      deb_cycles, deb_next;
  logic             pending, pending_next, pend_set, w1c;
  logic             ack, irq, irq_next;
  logic [31:0]      rdata, dat, dat_next;
  logic             hit, accept, wr, pin_level, req;
  logic [1:0]       offset;
  logic             unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  assign hit    = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign accept = wbs_stb_i & wbs_cyc_i & hit & ~ack;
  assign wr     = accept & wbs_we_i;
  assign offset = wbs_adr_i[3:2];

  power_switch_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .CW         (16)
  ) u_debounce (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .pin      (pin_req_i),
    .threshold(deb_cycles),
    .level    (pin_level)
  );

  assign req     = ctrl[CTRL_SRC] ? pin_level : ctrl[CTRL_SW_EN];
  assign reload  = step_reload(step);
  assign gate_up = (gate << 1) | N_SEG'(1'b1);
  assign gate_dn = gate >> 1;

  // Ramp FSM: one gate bit changes per step; dropping to zero lands in OFF.
  always_comb begin
    state_next = state;
    gate_next  = gate;
    timer_next = timer;
    pend_set   = 1'b0;
    case (state)
      ST_OFF: begin
        if (req) begin
          state_next = ST_RAMP_UP;
          gate_next  = gate_up;
          timer_next = reload;
        end else begin
          gate_next  = {N_SEG{1'b0}};
        end
      end
      ST_RAMP_UP, ST_ON: begin
        if (!req) begin
          gate_next  = gate_dn;
          timer_next = reload;
          state_next = (gate_dn == {N_SEG{1'b0}}) ? ST_OFF : ST_RAMP_DOWN;
        end else if (state == ST_ON) begin
          state_next = ST_ON;
        end else if (timer != 16'd0) begin
          timer_next = timer - 16'd1;
        end else if (!gate[N_SEG-1]) begin
          gate_next  = gate_up;
          timer_next = reload;
        end else begin
          state_next = ST_ON;
          pend_set   = 1'b1;
        end
      end
      ST_RAMP_DOWN: begin
        if (req) begin
          state_next = ST_RAMP_UP;
          gate_next  = gate_up;
          timer_next = reload;
        end else if (timer != 16'd0) begin
          timer_next = timer - 16'd1;
        end else begin
          gate_next  = gate_dn;
          timer_next = reload;
          if (gate_dn == {N_SEG{1'b0}}) begin
            state_next = ST_OFF;
            pend_set   = 1'b1;
          end else begin
            state_next = ST_RAMP_DOWN;
          end
        end
      end
      default: begin
        state_next = ST_OFF;
        gate_next  = {N_SEG{1'b0}};
      end
    endcase
    pg_next = (state_next == ST_ON);
  end

  // Register writes, W1C on pending, and read mux sampled at acceptance.
  always_comb begin
    ctrl_next = ctrl;
    step_next = step;
    deb_next  = deb_cycles;
    w1c       = 1'b0;
    if (wr) begin
      case (offset)
        REG_CTRL: begin
          if (wbs_sel_i[0]) ctrl_next = wbs_dat_i[2:0];
          else              ctrl_next = ctrl;
        end
        REG_STEP: begin
          if (wbs_sel_i[0]) step_next[7:0] = wbs_dat_i[7:0];
          else              step_next[7:0] = step[7:0];
          if (wbs_sel_i[1]) step_next[15:8] = wbs_dat_i[15:8];
          else              step_next[15:8] = step[15:8];
        end
        REG_DEBOUNCE: begin
          if (wbs_sel_i[0]) deb_next[7:0] = wbs_dat_i[7:0];
          else              deb_next[7:0] = deb_cycles[7:0];
          if (wbs_sel_i[1]) deb_next[15:8] = wbs_dat_i[15:8];
          else              deb_next[15:8] = deb_cycles[15:8];
        end
        REG_STATUS: w1c = wbs_sel_i[0] & wbs_dat_i[STAT_PEND];
        default:    w1c = 1'b0;
      endcase
    end else begin
      w1c = 1'b0;
    end
    pending_next = pend_set | (pending & ~w1c);
    irq_next     = pending_next & ctrl_next[CTRL_IRQ_EN];

    rdata = 32'd0;
    case (offset)
      REG_CTRL:     rdata[2:0]  = ctrl;
      REG_STEP:     rdata[15:0] = step;
      REG_DEBOUNCE: rdata[15:0] = deb_cycles;
      REG_STATUS: begin
        rdata[1:0]                 = state;
        rdata[STAT_PG]             = pg;
        rdata[STAT_PEND]           = pending;
        rdata[STAT_GATE +: N_SEG]  = gate;
      end
      default:      rdata = 32'd0;
    endcase
    dat_next = (accept & ~wbs_we_i) ? rdata : 32'd0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= ST_OFF;
      gate       <= {N_SEG{1'b0}};
      timer      <= 16'd0;
      pg         <= 1'b0;
      ctrl       <= 3'd0;
      step       <= STEP_RST;
      deb_cycles <= DEB_RST;
      pending    <= 1'b0;
      irq        <= 1'b0;
      ack        <= 1'b0;
      dat        <= 32'd0;
    end else begin
      state      <= state_next;
      gate       <= gate_next;
      timer      <= timer_next;
      pg         <= pg_next;
      ctrl       <= ctrl_next;
      step       <= step_next;
      deb_cycles <= deb_next;
      pending    <= pending_next;
      irq        <= irq_next;
      ack        <= accept;
      dat        <= dat_next;
    end
  end

  assign gate_o    = gate;
  assign pg_o      = pg;
  assign irq_o     = irq;
  assign wbs_ack_o = ack;
  assign wbs_dat_o = dat;

endmodule
